// File: rtl/traffic_pkg.sv
// Shared definitions for the lamp fault monitor: lamp index map, fault
// codes, FSM state encoding, default filter lengths and the first-fault
// record layout.
package traffic_pkg;

    localparam int unsigned NUM_LAMPS = 11;

    // Lamp index map shared by Cmd and Sense
    localparam int unsigned L_GREEN_A          = 0;
    localparam int unsigned L_YELLOW_A         = 1;
    localparam int unsigned L_RED_A            = 2;
    localparam int unsigned L_FLASH_YELLOW_A   = 3;
    localparam int unsigned L_GREEN_B          = 4;
    localparam int unsigned L_YELLOW_B         = 5;
    localparam int unsigned L_RED_B            = 6;
    localparam int unsigned L_FLASH_YELLOW_B   = 7;
    localparam int unsigned L_RED_CROSS        = 8;
    localparam int unsigned L_GREEN_CROSS      = 9;
    localparam int unsigned L_FLASH_GREEN_CROSS = 10;

    // Lamps whose current must follow the command level directly
    localparam logic [NUM_LAMPS-1:0] STEADY_MASK = 11'b011_0111_0111;

    localparam int unsigned DEF_CONFLICT_FILT = 2;
    localparam int unsigned DEF_DARK_FILT     = 3;
    localparam int unsigned DEF_SENSE_FILT    = 3;
    localparam int unsigned DEF_FLASH_TIMEOUT = 8;
    localparam int unsigned DEF_CLEAR_QUIET   = 4;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_DARK     = 3'd2,
        FC_SENSE    = 3'd3,
        FC_FLASH    = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_MONITOR  = 2'd0,
        ST_FAULT    = 2'd1,
        ST_CLEARING = 2'd2
    } state_e;

    typedef struct packed {
        fault_code_e code;
        logic [3:0]  lamp;
    } fault_rec_t;

    // Lamp index of the k-th flashing lamp (0: A, 1: B, 2: crossing)
    function automatic logic [3:0] flash_lamp(input int unsigned k);
        case (k)
            0:       return 4'(L_FLASH_YELLOW_A);
            1:       return 4'(L_FLASH_YELLOW_B);
            default: return 4'(L_FLASH_GREEN_CROSS);
        endcase
    endfunction

endpackage

// File: rtl/lamp_persist_filter.sv
// Saturating persistence filter. Counts consecutive cycles in which raw_i
// is high while en_i is high; any low cycle on either clears the count.
// hit_o is high on the cycle in which the run length reaches FILT and on
// every following cycle the condition persists.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active-low
//   en_i   : filter enable, 0 holds the count at 0
//   raw_i  : raw condition
//   hit_o  : condition has persisted FILT cycles (combinational)
module lamp_persist_filter #(
    parameter int unsigned FILT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic raw_i,
    output logic hit_o
);

    localparam int unsigned W = (FILT < 2) ? 1 : $clog2(FILT + 1);
    localparam logic [W-1:0] MAX_CNT = W'(FILT);
    localparam logic [W-1:0] HIT_CNT = W'(FILT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || !raw_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag on the cycle that completes the FILT-long run, so the fault is
    // taken on the same edge the counter would reach FILT.
    assign hit_o = en_i && raw_i && (cnt_q >= HIT_CNT);

endmodule

// File: rtl/lamp_fault_monitor.sv
// Lamp fault monitor. Checks lamp commands against each other and against
// synchronised current-sense feedback, latches the first fault, counts
// fault entries and releases after a FaultClear handshake followed by a
// quiet period.
//   Clk           : system clock
//   Rst           : asynchronous reset, active-low
//   Enable        : 1 = monitoring active
//   Cmd[10:0]     : lamp commands (synchronous)
//   Sense[10:0]   : lamp current present (asynchronous)
//   FaultClear    : single-cycle clear request
//   FailureDetect : latched fault indication
//   FaultCode     : first-fault code
//   FaultLamp     : first-fault lamp / approach index
//   FaultCount    : fault entries since reset, saturating at 255
module lamp_fault_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CONFLICT_FILT = DEF_CONFLICT_FILT,
    parameter int unsigned DARK_FILT     = DEF_DARK_FILT,
    parameter int unsigned SENSE_FILT    = DEF_SENSE_FILT,
    parameter int unsigned FLASH_TIMEOUT = DEF_FLASH_TIMEOUT,
    parameter int unsigned CLEAR_QUIET   = DEF_CLEAR_QUIET
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [10:0] Cmd,
    input  logic [10:0] Sense,
    input  logic        FaultClear,
    output logic        FailureDetect,
    output logic [2:0]  FaultCode,
    output logic [3:0]  FaultLamp,
    output logic [7:0]  FaultCount
);

    localparam int unsigned QW = $clog2(CLEAR_QUIET + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(CLEAR_QUIET - 1);

    // Sense synchroniser plus one extra stage on the flashing lamps for edge detection
    logic [10:0] sense_meta_q, sense_sync_q;
    logic [2:0]  flash_prev_q;
    logic [2:0]  flash_sync, flash_edge;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sense_meta_q <= '0;
            sense_sync_q <= '0;
            flash_prev_q <= '0;
        end else begin
            sense_meta_q <= Sense;
            sense_sync_q <= sense_meta_q;
            flash_prev_q <= flash_sync;
        end
    end

    assign flash_sync = {sense_sync_q[L_FLASH_GREEN_CROSS],
                         sense_sync_q[L_FLASH_YELLOW_B],
                         sense_sync_q[L_FLASH_YELLOW_A]};
    assign flash_edge = flash_sync ^ flash_prev_q;

    // Raw conditions
    logic        a_go, b_go, x_go;
    logic [1:0]  raw_conf, hit_conf;
    logic [2:0]  raw_dark, hit_dark;
    logic [10:0] raw_sense, hit_sense;
    logic [2:0]  raw_flash, hit_flash;

    assign a_go = Cmd[L_GREEN_A] | Cmd[L_YELLOW_A];
    assign b_go = Cmd[L_GREEN_B] | Cmd[L_YELLOW_B];
    assign x_go = Cmd[L_GREEN_CROSS] | Cmd[L_FLASH_GREEN_CROSS];

    assign raw_conf[0] = a_go & b_go;
    assign raw_conf[1] = x_go & (a_go | b_go);

    assign raw_dark[0] = ~|Cmd[3:0];
    assign raw_dark[1] = ~|Cmd[7:4];
    assign raw_dark[2] = ~|Cmd[10:8];

    assign raw_sense = (Cmd ^ sense_sync_q) & STEADY_MASK;

    // A flashing lamp's run is the number of commanded cycles without a sense edge
    assign raw_flash[0] = Cmd[L_FLASH_YELLOW_A]    & ~flash_edge[0];
    assign raw_flash[1] = Cmd[L_FLASH_YELLOW_B]    & ~flash_edge[1];
    assign raw_flash[2] = Cmd[L_FLASH_GREEN_CROSS] & ~flash_edge[2];

    for (genvar g = 0; g < 2; g++) begin : g_conf
        lamp_persist_filter #(.FILT(CONFLICT_FILT)) u_filt (
            .clk_i(Clk), .rst_ni(Rst), .en_i(Enable), .raw_i(raw_conf[g]), .hit_o(hit_conf[g]));
    end
    for (genvar g = 0; g < 3; g++) begin : g_dark
        lamp_persist_filter #(.FILT(DARK_FILT)) u_filt (
            .clk_i(Clk), .rst_ni(Rst), .en_i(Enable), .raw_i(raw_dark[g]), .hit_o(hit_dark[g]));
    end
    for (genvar g = 0; g < 11; g++) begin : g_sense
        lamp_persist_filter #(.FILT(SENSE_FILT)) u_filt (
            .clk_i(Clk), .rst_ni(Rst), .en_i(Enable), .raw_i(raw_sense[g]), .hit_o(hit_sense[g]));
    end
    for (genvar g = 0; g < 3; g++) begin : g_flash
        lamp_persist_filter #(.FILT(FLASH_TIMEOUT)) u_filt (
            .clk_i(Clk), .rst_ni(Rst), .en_i(Enable), .raw_i(raw_flash[g]), .hit_o(hit_flash[g]));
    end

    // Priority encoder: scanned from lowest to highest priority so the last
    // writer is the highest class and, within a class, the lowest index.
    fault_rec_t flag_rec;
    logic       any_hit;

    always_comb begin
        flag_rec = '0;
        any_hit  = |{hit_conf, hit_dark, hit_sense, hit_flash};
        for (int i = 2; i >= 0; i--) begin
            if (hit_flash[i]) begin
                flag_rec.code = FC_FLASH;
                flag_rec.lamp = flash_lamp(i);
            end
        end
        for (int i = 10; i >= 0; i--) begin
            if (hit_sense[i]) begin
                flag_rec.code = FC_SENSE;
                flag_rec.lamp = 4'(i);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            if (hit_dark[i]) begin
                flag_rec.code = FC_DARK;
                flag_rec.lamp = 4'(i);
            end
        end
        if (hit_conf[1]) begin
            flag_rec.code = FC_CONFLICT;
            flag_rec.lamp = 4'd2;
        end
        if (hit_conf[0]) begin
            flag_rec.code = FC_CONFLICT;
            flag_rec.lamp = 4'd0;
        end
    end

    // FSM
    state_e        state_q, state_d;
    logic [QW-1:0] quiet_q, quiet_d;
    fault_rec_t    rec_q, rec_d;
    logic [7:0]    count_q, count_d;
    logic          fault_entry, capture, release_rec;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_MONITOR;
        end else begin
            state_q <= state_d;
        end
    end

    // Enable=0 freezes the state; a latched fault stays latched.
    always_comb begin
        state_d = state_q;
        if (Enable) begin
            case (state_q)
                ST_MONITOR:  if (any_hit) state_d = ST_FAULT;
                ST_FAULT:    if (FaultClear && !any_hit) state_d = ST_CLEARING;
                ST_CLEARING: begin
                    if (any_hit) begin
                        state_d = ST_FAULT;
                    end else if (quiet_q == QUIET_LAST) begin
                        state_d = ST_MONITOR;
                    end
                end
                default:     state_d = ST_MONITOR;
            endcase
        end
    end

    always_comb begin
        FailureDetect = (state_q != ST_MONITOR);
        fault_entry   = (state_d == ST_FAULT) && (state_q != ST_FAULT);
        capture       = (state_d == ST_FAULT) && (state_q == ST_MONITOR);
        release_rec   = (state_d == ST_MONITOR) && (state_q == ST_CLEARING);
    end

    // Datapath: quiet counter, first-fault record, saturating fault counter
    always_comb begin
        quiet_d = '0;
        if (state_q == ST_CLEARING && state_d == ST_CLEARING) begin
            quiet_d = Enable ? quiet_q + 1'b1 : quiet_q;
        end

        rec_d = rec_q;
        if (capture) begin
            rec_d = flag_rec;
        end else if (release_rec) begin
            rec_d = '0;
        end

        count_d = count_q;
        if (fault_entry && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            quiet_q <= '0;
            rec_q   <= '0;
            count_q <= '0;
        end else begin
            quiet_q <= quiet_d;
            rec_q   <= rec_d;
            count_q <= count_d;
        end
    end

    assign FaultCode  = rec_q.code;
    assign FaultLamp  = rec_q.lamp;
    assign FaultCount = count_q;

endmodule

// File: tb/tb_lamp_fault_monitor.sv
// Bench for lamp_fault_monitor: directed vectors, a behavioural model that
// tracks run lengths of each fault condition, an expected queue checked on
// every falling edge, and hand-computed checkpoints.
module tb_lamp_fault_monitor;

    localparam int EW = 16;
    // RedA + RedB + RedCrossing, sensed: a quiet intersection
    localparam logic [10:0] LEGAL = 11'h144;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Enable = 1'b1;
    logic [10:0] Cmd = '0;
    logic [10:0] Sense = '0;
    logic        FaultClear = 1'b0;
    logic        FailureDetect;
    logic [2:0]  FaultCode;
    logic [3:0]  FaultLamp;
    logic [7:0]  FaultCount;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    lamp_fault_monitor dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Cmd(Cmd), .Sense(Sense),
        .FaultClear(FaultClear), .FailureDetect(FailureDetect),
        .FaultCode(FaultCode), .FaultLamp(FaultLamp), .FaultCount(FaultCount));

    // Clock / reset
    initial forever #50 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int fd, input int code,
                             input int lamp, input int count);
        check({tag, ".fd"},    int'(FailureDetect), fd);
        check({tag, ".code"},  int'(FaultCode),     code);
        check({tag, ".lamp"},  int'(FaultLamp),     lamp);
        check({tag, ".count"}, int'(FaultCount),    count);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Behavioural model: run lengths per condition, sense seen two cycles late
    int steady_l[8] = '{0, 1, 2, 4, 5, 6, 8, 9};
    int flash_l[3]  = '{3, 7, 10};
    int run_cab, run_cx;
    int run_dark[3];
    int run_sense[8];
    int run_flash[3];
    logic [10:0] sense_hist[$];
    logic [10:0] m_prev_sync;
    bit m_fd, m_clearing;
    int m_quiet, m_code, m_lamp, m_count;
    logic [EW-1:0] exp_q[$];

    task automatic model_reset();
        run_cab = 0; run_cx = 0;
        for (int k = 0; k < 3; k++) begin run_dark[k] = 0; run_flash[k] = 0; end
        for (int k = 0; k < 8; k++) run_sense[k] = 0;
        sense_hist.delete();
        sense_hist.push_back(11'd0);
        sense_hist.push_back(11'd0);
        m_prev_sync = '0;
        m_fd = 0; m_clearing = 0; m_quiet = 0;
        m_code = 0; m_lamp = 0; m_count = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    initial begin
        logic [10:0] syn, edg;
        bit a, b, x, fault;
        int code, lamp;
        model_reset();
        forever begin
            @(posedge Clk or negedge Rst);
            if (!Rst) begin
                model_reset();
            end else begin
                syn = sense_hist[0];
                edg = syn ^ m_prev_sync;
                a = Cmd[0] || Cmd[1];
                b = Cmd[4] || Cmd[5];
                x = Cmd[9] || Cmd[10];
                if (Enable) begin
                    run_cab = (a && b) ? run_cab + 1 : 0;
                    run_cx  = (x && (a || b)) ? run_cx + 1 : 0;
                    run_dark[0] = (Cmd[3:0] == 0)  ? run_dark[0] + 1 : 0;
                    run_dark[1] = (Cmd[7:4] == 0)  ? run_dark[1] + 1 : 0;
                    run_dark[2] = (Cmd[10:8] == 0) ? run_dark[2] + 1 : 0;
                    for (int k = 0; k < 8; k++)
                        run_sense[k] = (Cmd[steady_l[k]] != syn[steady_l[k]]) ? run_sense[k] + 1 : 0;
                    for (int k = 0; k < 3; k++)
                        run_flash[k] = (Cmd[flash_l[k]] && !edg[flash_l[k]]) ? run_flash[k] + 1 : 0;
                end else begin
                    run_cab = 0; run_cx = 0;
                    for (int k = 0; k < 3; k++) begin run_dark[k] = 0; run_flash[k] = 0; end
                    for (int k = 0; k < 8; k++) run_sense[k] = 0;
                end
                code = 0; lamp = 0;
                if (run_cab >= 2) begin code = 1; lamp = 0; end
                else if (run_cx >= 2) begin code = 1; lamp = 2; end
                for (int k = 0; k < 3; k++)
                    if (code == 0 && run_dark[k] >= 3) begin code = 2; lamp = k; end
                for (int k = 0; k < 8; k++)
                    if (code == 0 && run_sense[k] >= 3) begin code = 3; lamp = steady_l[k]; end
                for (int k = 0; k < 3; k++)
                    if (code == 0 && run_flash[k] >= 8) begin code = 4; lamp = flash_l[k]; end
                fault = (code != 0);
                if (Enable) begin
                    if (!m_fd) begin
                        if (fault) begin
                            m_fd = 1; m_code = code; m_lamp = lamp;
                            if (m_count < 255) m_count++;
                        end
                    end else if (!m_clearing) begin
                        if (FaultClear && !fault) begin m_clearing = 1; m_quiet = 0; end
                    end else if (fault) begin
                        m_clearing = 0;
                        if (m_count < 255) m_count++;
                    end else begin
                        m_quiet++;
                        if (m_quiet == 4) begin
                            m_fd = 0; m_clearing = 0; m_code = 0; m_lamp = 0;
                        end
                    end
                end
                sense_hist.push_back(Sense);
                void'(sense_hist.pop_front());
                m_prev_sync = syn;
                exp_q.push_back({m_fd, 3'(m_code), 4'(m_lamp), 8'(m_count)});
            end
        end
    end

    // Scoreboard compare on every falling edge
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge Clk);
            if (!done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb.empty: no expectation at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb.fd",    int'(FailureDetect), int'(e[15]));
                    check("sb.code",  int'(FaultCode),     int'(e[14:12]));
                    check("sb.lamp",  int'(FaultLamp),     int'(e[11:8]));
                    check("sb.count", int'(FaultCount),    int'(e[7:0]));
                end
            end
        end
    end

    // Driver
    task automatic pulse_clear();
        FaultClear = 1'b1;
        tick(1);
        FaultClear = 1'b0;
    endtask

    initial begin
        // 1 reset
        Cmd   = 11'($urandom_range(0, 2047));
        Sense = 11'($urandom_range(0, 2047));
        #60 check_out("reset", 0, 0, 0, 0);
        #10 Rst = 1'b1; Cmd = LEGAL; Sense = LEGAL;
        tick(6);
        check_out("post_reset", 0, 0, 0, 0);

        // 2 conflict A/B
        Cmd = LEGAL | 11'h011; tick(1); Cmd = LEGAL;
        tick(3);
        check("conflict_1cyc.fd", int'(FailureDetect), 0);
        Cmd = LEGAL | 11'h011; tick(2);
        check_out("conflict", 1, 1, 0, 1);
        Cmd = LEGAL;

        // 5 clear handshake
        tick(1);
        pulse_clear();
        check("clearing.fd", int'(FailureDetect), 1);
        tick(3);
        check("clearing3.fd", int'(FailureDetect), 1);
        tick(1);
        check_out("released", 0, 0, 0, 1);

        // 3 burnt RedA
        Sense = LEGAL & ~11'h004;
        tick(4);
        check("burnt_early.fd", int'(FailureDetect), 0);
        tick(1);
        check_out("burnt", 1, 3, 2, 2);
        // clear while the sense mismatch is still flagged: ignored
        Sense = LEGAL;
        tick(1);
        pulse_clear();
        tick(5);
        check("clear_ignored.fd", int'(FailureDetect), 1);
        // enter CLEARING then reinject a conflict
        pulse_clear();
        Cmd = LEGAL | 11'h011; tick(2);
        check_out("reinject", 1, 3, 2, 3);
        Cmd = LEGAL;
        tick(1);
        pulse_clear();
        tick(4);
        check_out("released2", 0, 0, 0, 3);

        // 4 dead flasher B, sense stuck high
        Cmd = LEGAL | 11'h080; Sense = LEGAL | 11'h080;
        tick(10);
        check("flash_early.fd", int'(FailureDetect), 0);
        tick(1);
        check_out("flash", 1, 4, 7, 4);
        Cmd = LEGAL; Sense = LEGAL;
        tick(1);
        pulse_clear();
        tick(4);
        check_out("released3", 0, 0, 0, 4);
        // live flasher toggling every 4 cycles
        Cmd = LEGAL | 11'h080;
        for (int i = 0; i < 12; i++) begin
            Sense[7] = ~Sense[7];
            tick(4);
        end
        check("flash_toggle.fd", int'(FailureDetect), 0);
        Cmd = LEGAL; Sense = LEGAL;
        tick(3);

        // 6 Enable=0 during a dark crossing
        Enable = 1'b0;
        Cmd = LEGAL & ~11'h100;
        tick(10);
        check("enable_off.fd", int'(FailureDetect), 0);
        Cmd = LEGAL; Enable = 1'b1;
        tick(3);
        check("enable_on.fd", int'(FailureDetect), 0);
        // dark crossing with monitoring active
        Cmd = LEGAL & ~11'h100; Sense = LEGAL & ~11'h100;
        tick(2);
        check("dark_early.fd", int'(FailureDetect), 0);
        tick(1);
        check_out("dark", 1, 2, 2, 5);
        Cmd = LEGAL; Sense = LEGAL;
        tick(1);
        pulse_clear();
        tick(2);
        // reset mid-CLEARING
        #20 Rst = 1'b0;
        #10 check_out("rst_clearing", 0, 0, 0, 0);
        tick(1);
        #20 Rst = 1'b1;
        tick(4);
        check_out("post_rst2", 0, 0, 0, 0);

        // counter saturation: 260 fault entries
        Cmd = LEGAL | 11'h011; tick(2); Cmd = LEGAL;
        for (int i = 0; i < 259; i++) begin
            tick(1);
            pulse_clear();
            Cmd = LEGAL | 11'h011; tick(2); Cmd = LEGAL;
        end
        check_out("saturate", 1, 1, 0, 255);
        tick(1);
        pulse_clear();
        Cmd = LEGAL | 11'h011; tick(2); Cmd = LEGAL;
        check("saturate_hold.count", int'(FaultCount), 255);
        tick(2);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
